// File: rtl/servo_pwm_tx_gen.sv
// Servo PWM frame generator: UI prescaler, per-frame latched timing, shadowed pulse width.
// Latency: enable seen in IDLE -> frame_start/pwm_out one clk later; new width applies at the next frame start.
// Backpressure: none; width strobes are always accepted (last one per frame wins). Option macro: SERVO_PWM_TX_LIMIT_EN.
module servo_pwm_tx_gen #(
   parameter int MIN_UI_TICKS = 10,
   parameter int MAX_UI_TICKS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] ui_clk_ticks,
   input  logic [11:0] frame_ui_ticks,
   input  logic [11:0] pwm_tx_ui_ticks,
   input  logic        pwm_tx_ui_ticks_dv,
   output logic        pwm_out,
   output logic        frame_start,
   output logic        pending
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        start;

   logic [11:0] pre_cnt;     // clk count within the current UI
   logic [11:0] ui_cnt;      // UI count within the current frame
   logic [11:0] ui_len;      // latched clks per UI
   logic [11:0] frame_len;   // latched UIs per frame
   logic [11:0] act_w;       // latched pulse width in UI
   logic [11:0] shadow;      // next-frame pulse width

   logic        ui_tick;
   logic        frame_end;
   logic [11:0] ui_len_new;
   logic [11:0] frame_len_new;
   logic [11:0] w_lim;
   logic [11:0] w_new;

   assign ui_tick   = (pre_cnt == ui_len - 12'd1);
   assign frame_end = ui_tick && (ui_cnt == frame_len - 12'd1);

   // Degenerate timing inputs are widened so a frame always has a high and a low UI slot.
   assign ui_len_new    = (ui_clk_ticks == 12'd0) ? 12'd1 : ui_clk_ticks;
   assign frame_len_new = (frame_ui_ticks < 12'd2) ? 12'd2 : frame_ui_ticks;

`ifdef SERVO_PWM_TX_LIMIT_EN
   localparam logic [11:0] MIN_W = 12'(MIN_UI_TICKS);
   localparam logic [11:0] MAX_W = 12'(MAX_UI_TICKS);
   assign w_lim = (shadow < MIN_W) ? MIN_W : ((shadow > MAX_W) ? MAX_W : shadow);
`else
   assign w_lim = shadow;
   // Limits only matter in the limited build; an inverted pair still shows up in the elaborated hierarchy.
   if (MIN_UI_TICKS > MAX_UI_TICKS) begin : g_limits_inverted
   end
`endif

   // Width is capped one UI short of the frame so every frame keeps a low interval.
   assign w_new = (w_lim >= frame_len_new) ? (frame_len_new - 12'd1) : w_lim;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: frames start from IDLE or back-to-back at a boundary; enable is honoured only at boundaries.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (enable) start = 1'b1;
         end
         HIGH, LOW: begin
            if (frame_end) begin
               if (enable) start = 1'b1;
               else        state_nxt = IDLE;
            end else if (state == HIGH && ui_tick && (ui_cnt + 12'd1 == act_w)) begin
               state_nxt = LOW;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (start) state_nxt = (w_new != 12'd0) ? HIGH : LOW;
   end

   // Timing counters and per-frame latches; everything restarts from zero on each frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt   <= 12'd0;
         ui_cnt    <= 12'd0;
         ui_len    <= 12'd0;
         frame_len <= 12'd0;
         act_w     <= 12'd0;
      end else if (start) begin
         pre_cnt   <= 12'd0;
         ui_cnt    <= 12'd0;
         ui_len    <= ui_len_new;
         frame_len <= frame_len_new;
         act_w     <= w_new;
      end else if (state_nxt == IDLE) begin
         pre_cnt   <= 12'd0;
         ui_cnt    <= 12'd0;
      end else if (ui_tick) begin
         pre_cnt   <= 12'd0;
         ui_cnt    <= frame_end ? 12'd0 : ui_cnt + 12'd1;
      end else begin
         pre_cnt   <= pre_cnt + 12'd1;
      end
   end

   // Shadow width capture; a strobe on the apply edge lands in the shadow and waits for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= 12'd0;
         pending <= 1'b0;
      end else begin
         if (pwm_tx_ui_ticks_dv) shadow <= pwm_tx_ui_ticks;
         if (start)                   pending <= pwm_tx_ui_ticks_dv;
         else if (pwm_tx_ui_ticks_dv) pending <= 1'b1;
      end
   end

   // Registered outputs follow the next state so they line up with the first clk of each phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pwm_out     <= (state_nxt == HIGH);
         frame_start <= start;
      end
   end

endmodule
